// File: rtl/rc_timer_pkg.sv
// Shared types for the rc_timer_bank channel bank: channel FSM states and mode encoding.
package rc_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } chan_state_e;

    localparam logic ModePeriodic = 1'b0;
    localparam logic ModeOneShot  = 1'b1;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_timer_bank_if.sv
// Control/status bundle of rc_timer_bank. RC_TIMER_PRESCALE_EN adds the shared prescaler divisor.
interface rc_timer_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 10
`ifdef RC_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRE_W  = 8
`endif
);
    localparam int unsigned CH_W = rc_timer_pkg::ch_width(NUM_CH);

    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] clear;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_value;
    logic              cfg_one_shot;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] running;

`ifdef RC_TIMER_PRESCALE_EN
    logic [PRE_W-1:0]  pre_div;

    modport master (
        output enable, clear, cfg_we, cfg_ch, cfg_value, cfg_one_shot, pre_div,
        input  tick, done, running
    );
    modport slave (
        input  enable, clear, cfg_we, cfg_ch, cfg_value, cfg_one_shot, pre_div,
        output tick, done, running
    );
`else
    modport master (
        output enable, clear, cfg_we, cfg_ch, cfg_value, cfg_one_shot,
        input  tick, done, running
    );
    modport slave (
        input  enable, clear, cfg_we, cfg_ch, cfg_value, cfg_one_shot,
        output tick, done, running
    );
`endif

endinterface

// File: rtl/rc_timer_chan.sv
// One timer channel: terminal value, mode, count and IDLE/RUN/DONE state with registered outputs.
module rc_timer_chan
    import rc_timer_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned RESET_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic             enable,
    input  logic             clear,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_value,
    input  logic             wr_one_shot,
    output logic             tick,
    output logic             done,
    output logic             running
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        val_d   = val_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = done_q;

        // A write also clears the channel, so it subsumes a simultaneous clear.
        if (wr) begin
            val_d   = wr_value;
            mode_d  = wr_one_shot;
            count_d = '0;
            done_d  = 1'b0;
            state_d = StIdle;
        end else if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
            state_d = StIdle;
        end else if (state_q != StDone) begin
            if (!enable) begin
                state_d = StIdle;
            end else begin
                // The IDLE->RUN edge already counts, giving a period of V+1 enabled edges.
                state_d = StRun;
                if (stb) begin
                    if (count_q == val_q) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        if (mode_q == ModeOneShot) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            val_q   <= WIDTH'(RESET_VAL);
            mode_q  <= ModePeriodic;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign tick    = tick_q;
    assign done    = done_q;
    assign running = (state_q == StRun);

endmodule

// File: rtl/rc_timer_bank.sv
// NUM_CH-channel reconfigurable tick timer; optional shared prescaler under RC_TIMER_PRESCALE_EN.
module rc_timer_bank
    import rc_timer_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned RESET_VAL = 15
`ifdef RC_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRE_W     = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    rc_timer_bank_if.slave bus
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] wr;
    logic              stb;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] done_w;
    logic [NUM_CH-1:0] running_w;

    // Only selects below NUM_CH are decoded, so out-of-range writes fall through untouched.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
                wr[i] = 1'b1;
            end
        end
    end

`ifdef RC_TIMER_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    always_comb begin
        stb       = (pre_cnt_q == bus.pre_div);
        pre_cnt_d = stb ? '0 : pre_cnt_q + PRE_W'(1);
        if ((|bus.clear) || (|wr)) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`else
    assign stb = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rc_timer_chan #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .stb         (stb),
            .enable      (bus.enable[g]),
            .clear       (bus.clear[g]),
            .wr          (wr[g]),
            .wr_value    (bus.cfg_value),
            .wr_one_shot (bus.cfg_one_shot),
            .tick        (tick_w[g]),
            .done        (done_w[g]),
            .running     (running_w[g])
        );
    end

    assign bus.tick    = tick_w;
    assign bus.done    = done_w;
    assign bus.running = running_w;

endmodule

// File: tb/tb_rc_timer_bank.sv
// Directed bench for rc_timer_bank: expected Tick cycles are queued per channel and checked each cycle.
module tb_rc_timer_bank;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_q [NCH][$];
    logic exp_t;
    int   n, m, p, r, s, t, u, w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc_timer_bank_if #(.NUM_CH(NCH), .WIDTH(10)) bus ();

    rc_timer_bank #(
        .NUM_CH    (NCH),
        .WIDTH     (10),
        .RESET_VAL (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Every cycle each Tick must be high exactly when its queue head names this cycle.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            exp_t = 1'b0;
            if (exp_q[c].size() > 0 && exp_q[c][0] == cyc) begin
                exp_t = 1'b1;
                void'(exp_q[c].pop_front());
            end
            n_cmp++;
            assert (bus.tick[c] === exp_t) else begin
                n_fail++;
                $error("FAIL tick%0d at cycle %0d: observed %b expected %b",
                       c, cyc, bus.tick[c], exp_t);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_periodic(input int ch, input int first, input int period, input int last);
        for (int k = first; k <= last; k += period) exp_q[ch].push_back(k);
    endtask

    task automatic cfg_write(input int ch, input int v, input logic os);
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = ch[1:0];
        bus.cfg_value    = v[9:0];
        bus.cfg_one_shot = os;
        @(negedge clk);
        bus.cfg_we       = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.enable       = '0;
        bus.clear        = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_value    = '0;
        bus.cfg_one_shot = 1'b0;
`ifdef RC_TIMER_PRESCALE_EN
        bus.pre_div      = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_tick", 32'(bus.tick), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_running", 32'(bus.running), 0);

        // Channel 0, reset default V=15, periodic.
        n = cyc;
        bus.enable[0] = 1'b1;
        push_periodic(0, n + 16, 16, n + 50);
        @(negedge clk);
        chk("run0_on", 32'(bus.running[0]), 1);
        wait_until(n + 50);
        bus.enable[0] = 1'b0;
        @(negedge clk);
        chk("run0_off", 32'(bus.running[0]), 0);

        // Channel 1, one-shot V=3.
        cfg_write(1, 3, 1'b1);
        m = cyc;
        bus.enable[1] = 1'b1;
        exp_q[1].push_back(m + 4);
        @(negedge clk);
        chk("os_running", 32'(bus.running[1]), 1);
        chk("os_done_early", 32'(bus.done[1]), 0);
        wait_until(m + 4);
        chk("os_done", 32'(bus.done[1]), 1);
        chk("os_running_off", 32'(bus.running[1]), 0);
        repeat (20) @(negedge clk);
        chk("os_done_sticky", 32'(bus.done[1]), 1);
        bus.enable[1] = 1'b0;

        // Channel 2, V=0 periodic: tick every enabled cycle.
        cfg_write(2, 0, 1'b0);
        p = cyc;
        bus.enable[2] = 1'b1;
        push_periodic(2, p + 1, 1, p + 10);
        wait_until(p + 10);
        bus.enable[2] = 1'b0;
        repeat (5) @(negedge clk);
        r = cyc;
        bus.enable[2] = 1'b1;
        push_periodic(2, r + 1, 1, r + 5);
        wait_until(r + 5);
        bus.enable[2] = 1'b0;

        // Channel 0 resumes from held count 2, then Clear lands on its terminal cycle.
        s = cyc;
        bus.enable[0] = 1'b1;
        exp_q[0].push_back(s + 14);
        wait_until(s + 29);
        bus.clear[0] = 1'b1;
        @(negedge clk);
        bus.clear[0] = 1'b0;
        chk("clr_running", 32'(bus.running[0]), 0);
        chk("clr_done", 32'(bus.done[0]), 0);
        exp_q[0].push_back(s + 46);
        wait_until(s + 47);
        bus.enable[0] = 1'b0;

        // Channel 3: write on the terminal cycle suppresses the Tick, new V=2 applies.
        cfg_write(3, 5, 1'b0);
        t = cyc;
        bus.enable[3] = 1'b1;
        wait_until(t + 5);
        cfg_write(3, 2, 1'b0);
        chk("wr_term_running", 32'(bus.running[3]), 0);
        push_periodic(3, t + 9, 3, t + 15);
        wait_until(t + 15);
        bus.enable[3] = 1'b0;

        // Reset while channels are mid-count.
        u = cyc;
        bus.enable = 4'b1101;
        push_periodic(2, u + 1, 1, u + 7);
        push_periodic(3, u + 3, 3, u + 7);
        wait_until(u + 7);
        rst        = 1'b1;
        bus.enable = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_running", 32'(bus.running), 0);

        // After reset every channel is back to V=15 periodic.
        w = cyc;
        bus.enable = 4'b1111;
        for (int c = 0; c < NCH; c++) push_periodic(c, w + 16, 16, w + 33);
        wait_until(w + 33);
        chk("post_rst_done", 32'(bus.done), 0);
        chk("post_rst_running", 32'(bus.running), 32'hf);
        bus.enable = '0;

`ifdef RC_TIMER_PRESCALE_EN
        bus.pre_div = 8'd1;
        cfg_write(0, 2, 1'b0);
        p = cyc;
        bus.enable[0] = 1'b1;
        push_periodic(0, p + 6, 6, p + 18);
        wait_until(p + 18);
        bus.enable[0] = 1'b0;
`endif

        repeat (3) @(negedge clk);
        for (int c = 0; c < NCH; c++) chk($sformatf("drain%0d", c), 32'(exp_q[c].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
